// File: rtl/ysyx_25040101_mem_arbiter.sv
// Shares one memory port between instruction fetch (IFU) and load/store (LSU) requesters.
// LSU has priority, IFU gets a forced turn after a run of LSU grants, and a hung memory times out.
module ysyx_25040101_mem_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [ADDR_W-1:0]     ifu_addr,
   output logic                  ifu_rsp_valid,
   output logic                  ifu_rsp_err,
   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic [ADDR_W-1:0]     lsu_addr,
   input  logic                  lsu_wen,
   input  logic [DATA_W-1:0]     lsu_wdata,
   input  logic [DATA_W/8-1:0]   lsu_wmask,
   output logic                  lsu_rsp_valid,
   output logic                  lsu_rsp_err,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_wen,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wmask,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy
);

   localparam int unsigned MaskW     = DATA_W / 8;
   localparam int unsigned StarveW   = $clog2(STARVE_LIMIT + 1);
   localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
   localparam logic [7:0]          ToLast    = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StReq, StWaitRsp} state_e;

   state_e               state_q;
   logic                 owner_ifu_q;
   logic                 owner_lsu_q;
   logic [ADDR_W-1:0]    addr_q;
   logic                 wen_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [MaskW-1:0]     wmask_q;
   logic [StarveW-1:0]   starve_cnt_q;
   logic [7:0]           to_cnt_q;
   logic                 idle;
   logic                 ifu_win;
   logic                 lsu_win;

   // Grants are gated by reset so every output reads 0 while rst is low.
   always_comb begin
      idle    = rst && (state_q == StIdle);
      ifu_win = idle && ifu_req_valid && (!lsu_req_valid || (starve_cnt_q == StarveMax));
      lsu_win = idle && lsu_req_valid && !ifu_win;
   end

   always_comb begin
      ifu_req_ready = ifu_win;
      lsu_req_ready = lsu_win;
      mem_req_valid = (state_q == StReq);
      mem_addr      = addr_q;
      mem_wen       = wen_q;
      mem_wdata     = wdata_q;
      mem_wmask     = wmask_q;
      busy          = (state_q != StIdle);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         owner_ifu_q   <= 1'b0;
         owner_lsu_q   <= 1'b0;
         addr_q        <= '0;
         wen_q         <= 1'b0;
         wdata_q       <= '0;
         wmask_q       <= '0;
         starve_cnt_q  <= '0;
         to_cnt_q      <= '0;
         ifu_rsp_valid <= 1'b0;
         ifu_rsp_err   <= 1'b0;
         lsu_rsp_valid <= 1'b0;
         lsu_rsp_err   <= 1'b0;
         rsp_rdata     <= '0;
      end else begin
         ifu_rsp_valid <= 1'b0;
         ifu_rsp_err   <= 1'b0;
         lsu_rsp_valid <= 1'b0;
         lsu_rsp_err   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (ifu_win || lsu_win) begin
                  owner_ifu_q <= ifu_win;
                  owner_lsu_q <= lsu_win;
                  addr_q      <= ifu_win ? ifu_addr : lsu_addr;
                  wen_q       <= lsu_win && lsu_wen;
                  wdata_q     <= lsu_win ? lsu_wdata : '0;
                  wmask_q     <= lsu_win ? lsu_wmask : '0;
                  // Only LSU wins over a waiting IFU advance the starvation count.
                  if (ifu_win || !ifu_req_valid) begin
                     starve_cnt_q <= '0;
                  end else if (starve_cnt_q != StarveMax) begin
                     starve_cnt_q <= starve_cnt_q + 1'b1;
                  end
                  state_q <= StReq;
               end
            end
            StReq: begin
               if (mem_req_ready) begin
                  to_cnt_q <= '0;
                  state_q  <= StWaitRsp;
               end
            end
            StWaitRsp: begin
               to_cnt_q <= to_cnt_q + 8'd1;
               if (mem_rsp_valid) begin
                  rsp_rdata     <= mem_rdata;
                  ifu_rsp_valid <= owner_ifu_q;
                  lsu_rsp_valid <= owner_lsu_q;
                  state_q       <= StIdle;
               end else if (to_cnt_q == ToLast) begin
                  rsp_rdata     <= '0;
                  ifu_rsp_valid <= owner_ifu_q;
                  ifu_rsp_err   <= owner_ifu_q;
                  lsu_rsp_valid <= owner_lsu_q;
                  lsu_rsp_err   <= owner_lsu_q;
                  state_q       <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25040101_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: a vector table of single transactions
// plus hand-written sequences for contention, starvation, stalls, timeout and reset.
module tb_ysyx_25040101_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
   logic [31:0] ifu_addr;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
   logic [31:0] lsu_addr, lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic [31:0] rsp_rdata;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic        busy;

   int errors = 0;
   int checks = 0;

   ysyx_25040101_mem_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_ready (ifu_req_ready),
      .ifu_addr      (ifu_addr),
      .ifu_rsp_valid (ifu_rsp_valid),
      .ifu_rsp_err   (ifu_rsp_err),
      .lsu_req_valid (lsu_req_valid),
      .lsu_req_ready (lsu_req_ready),
      .lsu_addr      (lsu_addr),
      .lsu_wen       (lsu_wen),
      .lsu_wdata     (lsu_wdata),
      .lsu_wmask     (lsu_wmask),
      .lsu_rsp_valid (lsu_rsp_valid),
      .lsu_rsp_err   (lsu_rsp_err),
      .rsp_rdata     (rsp_rdata),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_wen       (mem_wen),
      .mem_wdata     (mem_wdata),
      .mem_wmask     (mem_wmask),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rdata     (mem_rdata),
      .busy          (busy)
   );

   logic [108:0] all_out;
   assign all_out = {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid,
                     lsu_rsp_err, rsp_rdata, mem_req_valid, mem_addr, mem_wen, mem_wdata,
                     mem_wmask, busy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected $finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        ifu_v;
      logic        lsu_v;
      logic [31:0] ifu_a;
      logic [31:0] lsu_a;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] rdata;
      int          lat;
      logic        exp_lsu;
      logic [31:0] exp_addr;
      logic        exp_wen;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_wmask;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One complete transaction starting from IDLE, memory answering lat cycles into WAIT_RSP.
   task automatic run_vec(input vec_t v);
      @(negedge clk);
      ifu_req_valid = v.ifu_v;  lsu_req_valid = v.lsu_v;
      ifu_addr = v.ifu_a;       lsu_addr = v.lsu_a;
      lsu_wen = v.wen;          lsu_wdata = v.wdata;  lsu_wmask = v.wmask;
      #1;
      check("ifu_req_ready", ifu_req_ready, !v.exp_lsu);
      check("lsu_req_ready", lsu_req_ready, v.exp_lsu);
      @(negedge clk);
      ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 1;
      ifu_addr = 32'hFFFF_FFF0; lsu_addr = 32'hFFFF_FFF4; lsu_wdata = 32'h1111_2222;
      lsu_wmask = 4'hA; lsu_wen = ~v.wen;
      #1;
      check("mem_req_valid", mem_req_valid, 1);
      check("mem_addr", mem_addr, v.exp_addr);
      check("mem_wen", mem_wen, v.exp_wen);
      check("mem_wdata", mem_wdata, v.exp_wdata);
      check("mem_wmask", mem_wmask, v.exp_wmask);
      @(negedge clk);
      mem_req_ready = 0;
      repeat (v.lat) @(negedge clk);
      mem_rsp_valid = 1; mem_rdata = v.rdata;
      @(negedge clk);
      mem_rsp_valid = 0; mem_rdata = 32'h0;
      #1;
      check("ifu_rsp_valid", ifu_rsp_valid, !v.exp_lsu);
      check("lsu_rsp_valid", lsu_rsp_valid, v.exp_lsu);
      check("rsp_rdata", rsp_rdata, v.rdata);
      check("rsp_err", {ifu_rsp_err, lsu_rsp_err}, 2'b00);
      check("busy_after_rsp", busy, 0);
   endtask

   // Both requesters held valid with a zero-latency memory; counts LSU grants before IFU wins.
   task automatic starve_run(output int n_lsu, output bit got_ifu, output bit both);
      n_lsu = 0; got_ifu = 0; both = 0;
      @(negedge clk);
      mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = 32'h0;
      ifu_req_valid = 1; lsu_req_valid = 1; lsu_wen = 0; ifu_addr = 32'h8000_0100;
      for (int i = 0; i < 60 && !got_ifu; i++) begin
         #1;
         if (ifu_req_ready && lsu_req_ready) both = 1;
         if (lsu_req_ready) n_lsu++;
         if (ifu_req_ready) got_ifu = 1;
         @(negedge clk);
      end
      ifu_req_valid = 0; lsu_req_valid = 0;
      repeat (3) @(negedge clk);
      mem_req_ready = 0; mem_rsp_valid = 0;
   endtask

   // IFU fetch with no response; optionally answer in the very cycle the timeout fires.
   task automatic timeout_run(input bit late);
      int  wcnt;
      bit  seen;
      wcnt = 0; seen = 0;
      @(negedge clk);
      ifu_req_valid = 1; ifu_addr = 32'h8000_5000;
      @(negedge clk);
      ifu_req_valid = 0; mem_req_ready = 1;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         mem_req_ready = 0; mem_rsp_valid = 0;
         #1;
         if (ifu_rsp_valid) seen = 1;
         else if (busy) begin
            wcnt++;
            if (late && wcnt == 255) begin
               mem_rsp_valid = 1; mem_rdata = 32'h55AA_55AA;
            end
         end
      end
      mem_rsp_valid = 0;
      check("to_pulse_seen", seen, 1);
      check("to_wait_cycles", wcnt, 255);
      check("to_err", ifu_rsp_err, !late);
      check("to_rdata", rsp_rdata, late ? 32'h55AA_55AA : 32'h0);
      check("to_lsu_quiet", lsu_rsp_valid, 0);
      check("to_busy", busy, 0);
   endtask

   initial begin
      int  n;
      bit  got, both;
      int  hs;

      vecs[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0010_0073, 0,
                  1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0};
      vecs[1] = '{1'b1, 1'b1, 32'h8000_0008, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF,
                  32'h0, 1, 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF};
      vecs[2] = '{1'b0, 1'b1, 32'h0, 32'h8000_2004, 1'b0, 32'hAAAA_5555, 4'h3, 32'h1234_5678,
                  2, 1'b1, 32'h8000_2004, 1'b0, 32'hAAAA_5555, 4'h3};
      vecs[3] = '{1'b1, 1'b0, 32'h8000_0004, 32'h8000_9999, 1'b1, 32'hFFFF_FFFF, 4'hF,
                  32'hCAFE_F00D, 0, 1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0};
      vecs[4] = '{1'b1, 1'b1, 32'h8000_000C, 32'h8000_3000, 1'b0, 32'h0, 4'h0, 32'h1357_9BDF,
                  3, 1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'h0};

      rst = 0;
      ifu_req_valid = 0; ifu_addr = 0;
      lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_outputs", all_out, 0);
      ifu_req_valid = 1; lsu_req_valid = 1;
      #1;
      check("reset_no_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
      ifu_req_valid = 0; lsu_req_valid = 0;
      @(negedge clk);
      rst = 1;

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Contention: LSU store first, IFU granted as lsu_rsp_valid pulses.
      @(negedge clk);
      ifu_req_valid = 1; ifu_addr = 32'h8000_0010;
      lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
      #1;
      check("both_lsu_ready", {ifu_req_ready, lsu_req_ready}, 2'b01);
      @(negedge clk);
      lsu_req_valid = 0; mem_req_ready = 1;
      #1;
      check("both_store_fields", {mem_wen, mem_addr, mem_wdata, mem_wmask},
            {1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF});
      check("both_ifu_wait", ifu_req_ready, 0);
      @(negedge clk);
      mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0;
      @(negedge clk);
      mem_rsp_valid = 0;
      #1;
      check("both_lsu_rsp", lsu_rsp_valid, 1);
      check("both_ifu_grant_same_cycle", ifu_req_ready, 1);
      @(negedge clk);
      ifu_req_valid = 0; mem_req_ready = 1;
      #1;
      check("both_ifu_fields", {mem_wen, mem_addr, mem_wmask}, {1'b0, 32'h8000_0010, 4'h0});
      @(negedge clk);
      mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0000_0013;
      @(negedge clk);
      mem_rsp_valid = 0;
      #1;
      check("both_ifu_rsp", {ifu_rsp_valid, lsu_rsp_valid, rsp_rdata}, {2'b10, 32'h0000_0013});

      // Starvation guard; the second run shows the counter went back to 0.
      for (int r = 0; r < 2; r++) begin
         starve_run(n, got, both);
         check("starve_ifu_granted", got, 1);
         check("starve_lsu_grants", n, 4);
         check("starve_one_ready", both, 0);
      end

      // REQ stall: fields stable for 5 cycles, exactly one handshake.
      hs = 0;
      @(negedge clk);
      lsu_req_valid = 1; lsu_addr = 32'h8000_4000; lsu_wen = 1;
      lsu_wdata = 32'h0BAD_F00D; lsu_wmask = 4'h5;
      #1;
      check("stall_grant", lsu_req_ready, 1);
      @(negedge clk);
      lsu_req_valid = 0; lsu_addr = 32'h0; lsu_wen = 0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("stall_stable", {mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask},
               {1'b1, 1'b1, 32'h8000_4000, 32'h0BAD_F00D, 4'h5});
         @(negedge clk);
      end
      mem_req_ready = 1;
      #1;
      if (mem_req_valid) hs++;
      @(negedge clk);
      mem_rsp_valid = 1; mem_rdata = 32'h1;
      #1;
      if (mem_req_valid) hs++;
      @(negedge clk);
      mem_rsp_valid = 0;
      #1;
      check("stall_rsp", lsu_rsp_valid, 1);
      if (mem_req_valid) hs++;
      @(negedge clk);
      #1;
      if (mem_req_valid) hs++;
      mem_req_ready = 0;
      check("stall_one_txn", hs, 1);

      // Timeout, then a stray response that must be ignored.
      timeout_run(1'b0);
      @(negedge clk);
      mem_rsp_valid = 1; mem_rdata = 32'h7777_7777;
      @(negedge clk);
      mem_rsp_valid = 0;
      #1;
      check("stray_no_pulse", {ifu_rsp_valid, lsu_rsp_valid, busy}, 3'b000);
      @(negedge clk);
      #1;
      check("stray_no_pulse_later", {ifu_rsp_valid, lsu_rsp_valid, busy}, 3'b000);

      timeout_run(1'b1);

      // Asynchronous reset in WAIT_RSP.
      @(negedge clk);
      ifu_req_valid = 1; ifu_addr = 32'h8000_6000;
      @(negedge clk);
      ifu_req_valid = 0; mem_req_ready = 1;
      @(negedge clk);
      mem_req_ready = 0;
      @(negedge clk);
      #2 rst = 0;
      #1;
      check("abort_outputs_zero", all_out, 0);
      @(negedge clk);
      mem_rsp_valid = 1; mem_rdata = 32'h4444_4444;
      @(negedge clk);
      mem_rsp_valid = 0;
      #1;
      check("abort_still_zero", all_out, 0);
      rst = 1;
      @(negedge clk);
      #1;
      check("abort_no_rsp", {ifu_rsp_valid, lsu_rsp_valid, busy}, 3'b000);
      run_vec('{1'b1, 1'b0, 32'h8000_0020, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0000_006F, 1,
                1'b0, 32'h8000_0020, 1'b0, 32'h0, 4'h0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
